// File: rtl/disp_scan4.sv
// disp_scan4: four-digit multiplexed 7-segment scanner with
// double-buffered value, dead time and leading-zero blanking.
module disp_scan4 #(
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [3:0]  digit_nibble,
  output logic        digit_blank,
  output logic        dp_out,
  output logic [3:0]  digit_sel,
  output logic        frame_start
);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
  } buf_t;

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLK  = 16'(BLANK_CYCLES);

  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_run;
  logic        r_ready;
  buf_t        r_pend;
  buf_t        r_act;
  logic [3:0]  r_nib;
  logic        r_blank;
  logic        r_dp;
  logic [3:0]  r_sel;
  logic        r_fs;

  logic [15:0] w_cnt_nxt;
  logic [1:0]  w_idx_nxt;
  logic        w_wrap;
  logic        w_frame;
  logic        w_show;
  logic        w_sel_on;
  logic        w_zero;
  logic        w_accept;

  // r_run distinguishes edge 0, which opens slot 0 without counting
  always_comb begin
    w_wrap    = r_run && (r_cnt == LAST);
    w_cnt_nxt = r_cnt + 16'd1;
    if (!r_run || w_wrap) w_cnt_nxt = '0;
    w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
    w_frame   = !r_run || (w_wrap && r_idx == 2'd3);
    w_show    = (w_cnt_nxt == BLK);
    w_sel_on  = (w_cnt_nxt >= BLK);
    w_accept  = value_valid && r_ready;
  end

  always_comb begin
    w_zero = 1'b0;
    unique case (w_idx_nxt)
      2'd0: w_zero = 1'b0;
      2'd1: w_zero = (r_act.value[15:4] == 12'd0);
      2'd2: w_zero = (r_act.value[15:8] == 8'd0);
      2'd3: w_zero = (r_act.value[15:12] == 4'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
    end else if (ena) begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_pend  <= '0;
      r_act   <= '0;
    end else if (w_accept) begin
      r_pend  <= '{value: value_in, dp: dp_in, lz: lz_blank};
      r_ready <= 1'b0;
    end else if (ena && w_frame && !r_ready) begin
      r_act   <= r_pend;
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib   <= '0;
      r_blank <= 1'b1;
      r_dp    <= 1'b0;
      r_sel   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_fs  <= ena && w_frame;
      r_sel <= '0;
      if (ena) begin
        if (w_sel_on) r_sel <= 4'b0001 << w_idx_nxt;
        if (w_show) begin
          r_nib   <= r_act.value[4*w_idx_nxt +: 4];
          r_dp    <= r_act.dp[w_idx_nxt];
          r_blank <= r_act.lz && w_zero;
        end
      end
    end
  end

  assign value_ready  = r_ready;
  assign digit_nibble = r_nib;
  assign digit_blank  = r_blank;
  assign dp_out       = r_dp;
  assign digit_sel    = r_sel;
  assign frame_start  = r_fs;

endmodule

// File: tb/tb_disp_scan4.sv
// tb_disp_scan4: directed self-checking bench for disp_scan4
// with PRESCALE=8, BLANK_CYCLES=2.
module tb_disp_scan4;

  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] val;
  logic [3:0]  dpi;
  logic        lz;
  logic        vv;
  logic        ready;
  logic [3:0]  nib;
  logic        blank;
  logic        dpo;
  logic [3:0]  sel;
  logic        fs;

  int n;
  int checks;
  int errors;

  disp_scan4 #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .value_in(val),
    .dp_in(dpi),
    .lz_blank(lz),
    .value_valid(vv),
    .value_ready(ready),
    .digit_nibble(nib),
    .digit_blank(blank),
    .dp_out(dpo),
    .digit_sel(sel),
    .frame_start(fs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got %h want %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (ena && rst_n) n++;
    #1;
  endtask

  task automatic run_to(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 1000) begin
      step();
      guard++;
    end
    chk("run_to", 16'(n), 16'(t));
  endtask

  task automatic chk_frame(input int base,
                           input logic [15:0] enib,
                           input logic [3:0] edp,
                           input logic [3:0] ebl);
    logic [3:0] esel;
    for (int k = 0; k < 4; k++) begin
      run_to(base + P * k + 1);
      chk("dead", 16'(sel), 16'h0);
      run_to(base + P * k + B);
      esel = 4'b0001 << k;
      chk("sel", 16'(sel), 16'(esel));
      chk("nib", 16'(nib), 16'(enib[4*k +: 4]));
      chk("dp", 16'(dpo), 16'(edp[k]));
      chk("blank", 16'(blank), 16'(ebl[k]));
    end
  endtask

  initial begin
    int nfs;
    logic [3:0] esel;
    logic efs;
    checks = 0;
    errors = 0;
    n = -1;
    rst_n = 1'b1;
    ena = 1'b0;
    vv = 1'b0;
    val = '0;
    dpi = '0;
    lz = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_nib", 16'(nib), 16'h0);
    chk("rst_blank", 16'(blank), 16'h1);
    chk("rst_dp", 16'(dpo), 16'h0);
    chk("rst_fs", 16'(fs), 16'h0);

    rst_n = 1'b1;
    ena = 1'b1;
    step();
    chk("e0_fs", 16'(fs), 16'h1);
    chk("e0_sel", 16'(sel), 16'h0);
    step();
    chk("e1_fs", 16'(fs), 16'h0);
    chk("e1_sel", 16'(sel), 16'h0);
    step();
    chk("e2_sel", 16'(sel), 16'h1);
    chk("e2_blank", 16'(blank), 16'h0);
    step();

    // asynchronous reset mid-slot, checked before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 16'(sel), 16'h0);
    chk("arst_blank", 16'(blank), 16'h1);
    chk("arst_fs", 16'(fs), 16'h0);
    chk("arst_ready", 16'(ready), 16'h1);
    step();
    rst_n = 1'b1;
    n = -1;

    // scan sequence
    vv = 1'b1;
    val = 16'h1234;
    dpi = 4'b0100;
    lz = 1'b0;
    step();
    chk("acc_ready", 16'(ready), 16'h0);
    chk("acc_fs", 16'(fs), 16'h1);
    vv = 1'b0;
    run_to(32);
    chk("f32_fs", 16'(fs), 16'h1);
    chk("f32_ready", 16'(ready), 16'h1);
    chk_frame(32, 16'h1234, 4'b0100, 4'b0000);
    chk_frame(64, 16'h1234, 4'b0100, 4'b0000);

    // leading-zero blanking
    vv = 1'b1;
    val = 16'h0040;
    dpi = 4'b0000;
    lz = 1'b1;
    step();
    vv = 1'b0;
    chk_frame(96, 16'h0040, 4'b0000, 4'b1100);
    vv = 1'b1;
    val = 16'h0000;
    dpi = 4'b1000;
    lz = 1'b1;
    step();
    vv = 1'b0;
    chk_frame(128, 16'h0000, 4'b1000, 4'b1110);

    // backpressure: A accepted mid-frame, B held until ready
    vv = 1'b1;
    val = 16'hABCD;
    dpi = 4'b0001;
    lz = 1'b0;
    step();
    chk("bp_a_ready", 16'(ready), 16'h0);
    val = 16'h5678;
    dpi = 4'b0010;
    run_to(159);
    chk("bp_hold_ready", 16'(ready), 16'h0);
    run_to(160);
    chk("bp_xfer_ready", 16'(ready), 16'h1);
    chk("bp_xfer_fs", 16'(fs), 16'h1);
    step();
    chk("bp_b_ready", 16'(ready), 16'h0);
    vv = 1'b0;
    chk_frame(160, 16'hABCD, 4'b0001, 4'b0000);
    chk_frame(192, 16'h5678, 4'b0010, 4'b0000);

    // ena gating mid-slot
    run_to(228);
    chk("pre_gate_sel", 16'(sel), 16'h1);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gate_sel", 16'(sel), 16'h0);
      chk("gate_nib", 16'(nib), 16'h8);
    end
    ena = 1'b1;
    step();
    chk("resume_sel", 16'(sel), 16'h1);
    run_to(231);
    chk("resume_last", 16'(sel), 16'h1);
    run_to(232);
    chk("next_dead", 16'(sel), 16'h0);
    run_to(234);
    chk("next_sel", 16'(sel), 16'h2);
    chk("next_nib", 16'(nib), 16'h7);

    // two full frames: idx order and frame_start period
    run_to(255);
    nfs = 0;
    for (int i = 0; i < 2 * 4 * P; i++) begin
      step();
      efs = (n % (4 * P) == 0);
      esel = (n % P >= B) ? 4'b0001 << ((n / P) % 4) : 4'b0000;
      if (fs) nfs++;
      chk("wrap_fs", 16'(fs), 16'(efs));
      chk("wrap_sel", 16'(sel), 16'(esel));
    end
    chk("fs_count", 16'(nfs), 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan4.md
# disp_scan4

Four-digit time-multiplexed display scanner for a common-cathode 7-segment module. Accepts a 16-bit hex value (4 nibbles) with decimal points and leading-zero control over a valid/ready handshake. Double-buffers the value so updates land only on frame boundaries. Each digit slot drives one nibble plus blank and dp flags to the downstream seven-segment decoder, and asserts a one-hot digit select, with dead time between digits to prevent ghosting.

## Interface
- PRESCALE, 1024: clock cycles per digit slot; legal range 4..65535.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot; 1 <= BLANK_CYCLES < PRESCALE.
- clk  input  1  clock; one clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  when low, all counters hold and digit_sel is forced to 0.
- value_in  input  16  four hex digits; digit i = value_in[4i+3:4i]; digit 0 is least significant.
- dp_in  input  4  decimal point per digit, bit i belongs to digit i.
- lz_blank  input  1  enables leading-zero blanking for this value.
- value_valid  input  1  source offers value_in/dp_in/lz_blank.
- value_ready  output  1  pending buffer is empty, so the offer can be accepted.
- digit_nibble  output  4  nibble for the current digit, to the decoder.
- digit_blank  output  1  decoder must drive all segments off.
- dp_out  output  1  decimal point for the current digit.
- digit_sel  output  4  one-hot active-high digit enable; 0 during dead time.
- frame_start  output  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- Counting: slot_cnt counts 0..PRESCALE-1 and then wraps. idx (2 bits) increments on each slot wrap: 0,1,2,3,0,...
- Counters advance only on edges with ena=1.
- Buffers: there are two, pending and active. Each holds {value, dp, lz}.
- Accept: on value_valid && value_ready, the payload is captured into pending and pending_full is set. value_ready = !pending_full.
- Transfer: at each frame boundary (slot_cnt wraps to 0 with idx becoming 0), if pending_full, active <= pending and pending_full is cleared. value_ready is 1 from the next cycle.
- No simultaneous accept and transfer: accept is impossible while pending is full.
- Dead time: for slot_cnt < BLANK_CYCLES, digit_sel = 0.
- Digit display: from slot_cnt = BLANK_CYCLES to the end of the slot, digit_sel = 1 << idx.
- Latched at dead-time end (the edge where slot_cnt reaches BLANK_CYCLES), held through the rest of the slot:
  - digit_nibble = active.value nibble idx.
  - dp_out = active.dp[idx].
  - digit_blank = active.lz && idx>0 && active.value[15:4*idx]==0.
- Digit 0 is never blanked. dp_out is not affected by blanking.
- ena low: all state and outputs hold, except digit_sel = 0 and frame_start = 0. The handshake still operates.
- Reset (asynchronous, any time, mid-frame included):
  - slot_cnt=0, idx=0, both buffers 0, pending_full=0.
  - Outputs: value_ready=1, digit_sel=0, digit_nibble=0, digit_blank=1, dp_out=0, frame_start=0.

## Timing
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- Edge numbering: edge n is the nth rising clk edge with ena=1 after rst_n deasserts, n starting at 0. Edge 0 begins slot 0 (idx 0).
- frame_start: high for the one cycle after every edge n with n mod (4*PRESCALE) == 0, including n=0.
- Transfer: occurs at those same edges. The newly transferred value is first shown BLANK_CYCLES edges later.
- digit_sel: nonzero for exactly PRESCALE-BLANK_CYCLES consecutive cycles per slot.
- Full refresh period: 4*PRESCALE cycles.
- Handshake latency:
  - value_ready falls the cycle after acceptance.
  - Worst-case display latency from acceptance to visible digit 0 is 4*PRESCALE+BLANK_CYCLES cycles.
- Payload held by the source while value_ready=0 is not sampled.

## Test plan
Bench parameters: PRESCALE=8, BLANK_CYCLES=2.
- Reset check: assert rst_n low mid-slot with digit_sel active -> all outputs go to reset values without waiting for clk. After release, frame_start=1 after edge 0 and digit_sel=4'b0001 after edge 2.
- Scan sequence: accept 16'h1234, dp_in=4'b0100, lz=0, then run 3 frames. Required per slot after dead time:
  - idx0: nibble 4, dp 0, sel 0001.
  - idx1: nibble 3, sel 0010.
  - idx2: nibble 2, dp 1.
  - idx3: nibble 1, sel 1000.
  - digit_sel must be 0 for 2 cycles at each slot start.
- Leading-zero blanking: value 16'h0040, lz=1 -> digit_blank is 1 for idx2 and idx3 and 0 for idx0 and idx1. Value 16'h0000, lz=1 -> only idx0 is unblanked.
- Handshake backpressure: offer A mid-frame, then hold B valid -> value_ready=0 until the frame boundary; A is shown next frame; B is accepted the cycle after ready rises and is shown one frame later.
- ena gating: drop ena for 5 cycles mid-slot -> digit_sel=0 and the slot count frozen. After ena returns, the slot completes with its remaining cycles and no skipped digit.
- Wrap: run for 2 full frames -> idx order is 0,1,2,3,0, and frame_start pulses exactly every 32 cycles.
